// File: rtl/block_dispatch.sv
// block_dispatch: grid-level scheduler handing block IDs to compute units and counting retirements
module block_dispatch #(
    parameter int NUM_CORES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [31:0]                 num_threads,
    input  logic [31:0]                 block_dim,
    input  logic [NUM_CORES-1:0]        core_block_done,
    output logic [NUM_CORES-1:0]        core_rst,
    output logic [NUM_CORES-1:0]        core_enable,
    output logic [NUM_CORES-1:0][31:0]  core_block_id,
    output logic [31:0]                 blocks_done,
    output logic                        kernel_done,
    output logic                        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} g_state_t;
    typedef enum logic [1:0] {FREE, LOAD, EXEC} c_state_t;
    g_state_t gs;
    c_state_t cs [NUM_CORES];
    logic [31:0] num_blocks, next_block, ret_cnt, launch_blocks;
    logic [32:0] thread_sum;
    logic [NUM_CORES-1:0] grant, retire;
    logic found;
    // 33-bit sum keeps the ceiling division free of overflow
    assign thread_sum = {1'b0, num_threads} + {1'b0, block_dim} - 33'd1;
    assign launch_blocks = block_dim == '0 ? '0 : 32'(thread_sum / {1'b0, block_dim});
    always_comb begin
        grant = '0;
        retire = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            retire[i] = gs == RUN && cs[i] == EXEC && core_block_done[i];
            grant[i] = gs == RUN && cs[i] == FREE && next_block < num_blocks && !found;
            found = found | grant[i];
        end
        ret_cnt = 32'($countones(retire));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gs <= IDLE;
            num_blocks <= '0;
            next_block <= '0;
            blocks_done <= '0;
            kernel_done <= 1'b0;
            busy <= 1'b0;
            core_rst <= '0;
            core_enable <= '0;
            core_block_id <= '1;
            for (int i = 0; i < NUM_CORES; i++) cs[i] <= FREE;
        end else begin
            case (gs)
                IDLE: if (start) begin
                    num_blocks <= launch_blocks;
                    next_block <= '0;
                    blocks_done <= '0;
                    kernel_done <= 1'b0;
                    busy <= 1'b1;
                    gs <= RUN;
                end
                RUN: begin
                    blocks_done <= blocks_done + ret_cnt;
                    next_block <= next_block + 32'(|grant);
                    if (blocks_done == num_blocks) gs <= DONE;
                end
                DONE: begin
                    kernel_done <= 1'b1;
                    busy <= 1'b0;
                    gs <= IDLE;
                end
                default: gs <= IDLE;
            endcase
            // a done flag seen in FREE or LOAD is stale from the previous block
            for (int i = 0; i < NUM_CORES; i++) begin
                if (grant[i]) begin
                    core_block_id[i] <= next_block;
                    core_rst[i] <= 1'b1;
                    cs[i] <= LOAD;
                end else if (gs == RUN && cs[i] == LOAD) begin
                    core_rst[i] <= 1'b0;
                    core_enable[i] <= 1'b1;
                    cs[i] <= EXEC;
                end else if (retire[i]) begin
                    core_enable[i] <= 1'b0;
                    core_block_id[i] <= '1;
                    cs[i] <= FREE;
                end
            end
        end
    end
endmodule
